bip_fetch_unit: RTL and testbench
=================================

BIP_FETCH_UNIT -- requirements
Module: bip_fetch_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 11, program-memory address width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 16, instruction width: opcode [15:11], operand [10:0].
REQ-003 SHALL have parameter RESET_VECTOR, default 0, PC value after reset.
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 EN  input  1  run enable; gates the start of each new fetch.
REQ-007 PM_ADDR  output  PC_WIDTH  address to program memory, which registers it on CLK and returns PM_DATA one cycle later.
REQ-008 PM_DATA  input  INSTR_WIDTH  program-memory read data.
REQ-009 INSTR_VALID  output  1  OPCODE/OPERAND hold a fetched instruction.
REQ-010 INSTR_READY  input  1  downstream accepts the instruction on the edge where VALID and READY are both 1.
REQ-011 OPCODE  output  5; OPERAND  output  11; PC  output  PC_WIDTH, address of the current instruction.
REQ-012 HALTED  output  1  HLT fetched; fetching stopped.
REQ-013 INSTR_COUNT  output  16  accepted-instruction count (see Configuration).

Function
REQ-014 FSM states SHALL be IDLE, FETCH, VALID and HALT.
REQ-015 IDLE: EN=1 -> FETCH; EN=0 -> stay in IDLE.
REQ-016 FETCH SHALL last exactly one cycle, capturing PM_DATA into the instruction register at its end; opcode 00000 (HLT) -> HALT, otherwise -> VALID.
REQ-017 VALID: INSTR_VALID=1; OPCODE, OPERAND and PC held stable until accepted.
REQ-018 VALID accept SHALL increment PC, then go to FETCH if EN=1, else to IDLE.
REQ-019 PM_ADDR SHALL be the combinational next PC, so memory samples the correct address on the edge that enters FETCH: PC+1 on an accepting edge, PC otherwise.
REQ-020 PC increment SHALL wrap modulo 2^PC_WIDTH (0x7FF -> 0x000).
REQ-021 Latency: first INSTR_VALID SHALL rise 2 cycles after the first rising edge with EN=1 in IDLE; with READY held at 1, throughput is one instruction per 2 cycles.
REQ-022 HALT: HALTED=1, INSTR_VALID=0, PC holds the HLT address; exit only by reset.
REQ-023 EN deasserted in FETCH or VALID SHALL NOT abort the in-flight instruction.
REQ-024 READY while INSTR_VALID=0 SHALL have no effect.

Reset
REQ-025 While RESET=0: state=IDLE, PC=RESET_VECTOR, OPCODE=0, OPERAND=0, INSTR_VALID=0, HALTED=0, INSTR_COUNT=0, regardless of CLK.
REQ-026 Reset asserted mid-fetch or in HALT SHALL discard the instruction immediately; operation restarts from IDLE after release.

Configuration
REQ-027 Macro BIP_FETCH_COUNT_EN defined: INSTR_COUNT increments on each accept and saturates at 0xFFFF.
REQ-028 Macro undefined: INSTR_COUNT tied to 0 and no counter logic is synthesised.

Structure
REQ-029 Shared package bip_pkg SHALL hold the opcode constants (HLT=00000, STO, LDV, LDI, ADD, ADI, SUB, SBI = 00001..00111), the field widths and the FSM state encoding.
REQ-030 A sub-module bip_pc_reg SHALL hold the PC register and its next-PC/wrap logic; the FSM and instruction register stay in bip_fetch_unit.

Verification
REQ-031 Memory {0x1005, 0x2803, 0x0000}, EN=1, READY=1 -> VALID with OPCODE 00010/OPERAND 0x005 at PC 0, then 00101/0x003 at PC 1, then HALTED=1 with PC=2 and VALID=0.
REQ-032 READY held 0 for 5 cycles in VALID -> OPCODE, OPERAND and PC stable; READY=1 -> PC+1 and PM_ADDR=PC+1 on the same cycle.
REQ-033 RESET_VECTOR=0x7FF, non-HLT word at 0x7FF -> after accept, PC=0x000 and address 0 is fetched.
REQ-034 RESET pulsed low while in VALID -> INSTR_VALID=0 and PC=RESET_VECTOR with no clock edge; clean restart after release.
REQ-035 EN=0 at the accepting edge -> IDLE with PC incremented; EN=1 -> next instruction valid 2 cycles later.
REQ-036 With BIP_FETCH_COUNT_EN defined, 3 accepts -> INSTR_COUNT=3; with it undefined -> INSTR_COUNT=0.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared BIP definitions: opcode constants, instruction field widths and the
// fetch FSM state encoding.
package bip_pkg;

  localparam int unsigned OPCODE_W  = 5;
  localparam int unsigned OPERAND_W = 11;
  localparam int unsigned COUNT_W   = 16;

  localparam logic [OPCODE_W-1:0] OP_HLT = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_STO = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_LDV = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_LDI = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_ADD = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_ADI = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_SUB = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SBI = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [OPERAND_W-1:0] operand;
  } instr_t;

endpackage

// File: rtl/bip_pc_reg.sv
// Program counter with increment-and-wrap; pc_next_c is the address the
// program memory must sample on the coming edge.
module bip_pc_reg #(
  parameter int unsigned           PC_WIDTH     = 11,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_next_c
);

  // Natural overflow of the PC_WIDTH-bit add gives the modulo wrap.
  assign pc_next_c = inc ? pc + PC_WIDTH'(1) : pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= RESET_VECTOR;
    else        pc <= pc_next_c;
  end

endmodule

// File: rtl/bip_fetch_unit.sv
// BIP instruction fetch unit: IDLE/FETCH/VALID/HALT sequencer with a
// valid/ready instruction output. Define BIP_FETCH_COUNT_EN for instr_count.
module bip_fetch_unit
  import bip_pkg::*;
#(
  parameter int unsigned           PC_WIDTH     = 11,
  parameter int unsigned           INSTR_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  output logic [PC_WIDTH-1:0]    pm_addr,
  input  logic [INSTR_WIDTH-1:0] pm_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [OPCODE_W-1:0]    opcode,
  output logic [OPERAND_W-1:0]   operand,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   halted,
  output logic [COUNT_W-1:0]     instr_count
);

  state_t state, state_next;
  logic   accept_c;
  logic   capture_c;
  instr_t ir;
  instr_t pm_word_c;

  assign pm_word_c.opcode  = pm_data[INSTR_WIDTH-1 -: OPCODE_W];
  assign pm_word_c.operand = pm_data[OPERAND_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state; EN only gates the start of a fetch, never an in-flight one.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (en) state_next = ST_FETCH;
      ST_FETCH: state_next = (pm_word_c.opcode == OP_HLT) ? ST_HALT : ST_VALID;
      ST_VALID: if (instr_ready) state_next = en ? ST_FETCH : ST_IDLE;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    accept_c  = 1'b0;
    capture_c = 1'b0;
    case (state)
      ST_FETCH: capture_c = 1'b1;
      ST_VALID: accept_c  = instr_ready;
      default:  ;
    endcase
  end

  bip_pc_reg #(
    .PC_WIDTH    (PC_WIDTH),
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .inc      (accept_c),
    .pc       (pc),
    .pc_next_c(pm_addr)
  );

  // Instruction register and status flags, registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir          <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      if (capture_c) ir <= pm_word_c;
      instr_valid <= (state_next == ST_VALID);
      halted      <= (state_next == ST_HALT);
    end
  end

  assign opcode  = ir.opcode;
  assign operand = ir.operand;

`ifdef BIP_FETCH_COUNT_EN
  // Saturating count of accepted instructions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) instr_count <= '0;
    else if (accept_c && (instr_count != {COUNT_W{1'b1}}))
      instr_count <= instr_count + COUNT_W'(1);
  end
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_bip_fetch_unit.sv
// Self-checking bench for bip_fetch_unit: directed table, multi-cycle corner
// sequences, and a randomized run against a transaction-level reference.
module tb_bip_fetch_unit;
  import bip_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        instr_ready;
  logic [15:0] pm_data, pm_data_w;
  logic [10:0] pm_addr, pm_addr_w, pc, pc_w;
  logic [4:0]  opcode, opcode_w;
  logic [10:0] operand, operand_w;
  logic        instr_valid, instr_valid_w, halted, halted_w;
  logic [15:0] instr_count, instr_count_w;

  logic [15:0] mem   [2048];
  logic [15:0] mem_w [2048];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Synchronous program memories: address registered, data one cycle later.
  always @(posedge clk) begin
    pm_data   <= mem[pm_addr];
    pm_data_w <= mem_w[pm_addr_w];
  end

  bip_fetch_unit u_dut (
    .clk(clk), .reset(reset), .en(en), .pm_addr(pm_addr), .pm_data(pm_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode),
    .operand(operand), .pc(pc), .halted(halted), .instr_count(instr_count)
  );

  bip_fetch_unit #(.RESET_VECTOR(11'h7FF)) u_dut_wrap (
    .clk(clk), .reset(reset), .en(en), .pm_addr(pm_addr_w), .pm_data(pm_data_w),
    .instr_valid(instr_valid_w), .instr_ready(instr_ready), .opcode(opcode_w),
    .operand(operand_w), .pc(pc_w), .halted(halted_w), .instr_count(instr_count_w)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef BIP_FETCH_COUNT_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return (n < 0) ? 16'hFFFF : 16'h0000;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic en, rdy;
    logic v; logic [4:0] op; logic [10:0] opd; logic [10:0] pc; logic h;
    logic wv; logic [4:0] wop; logic [10:0] wopd; logic [10:0] wpc; logic [10:0] waddr;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [15:0] w;
    logic [10:0] m_pc;
    bit          m_valid, m_halt, m_pending;
    int          acc;
    bit          done;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 5'd0, 11'h000, 11'h000, 1'b0, 1'b0, 5'd0, 11'h000, 11'h7FF, 11'h7FF};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 5'd2, 11'h005, 11'h000, 1'b0, 1'b1, 5'd1, 11'h001, 11'h7FF, 11'h000};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 5'd0, 11'h000, 11'h001, 1'b0, 1'b0, 5'd0, 11'h000, 11'h000, 11'h000};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 5'd5, 11'h003, 11'h001, 1'b0, 1'b1, 5'd2, 11'h002, 11'h000, 11'h001};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 5'd0, 11'h000, 11'h002, 1'b0, 1'b0, 5'd0, 11'h000, 11'h001, 11'h001};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 5'd0, 11'h000, 11'h002, 1'b1, 1'b1, 5'd1, 11'h000, 11'h001, 11'h002};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 5'd0, 11'h000, 11'h002, 1'b1, 1'b0, 5'd0, 11'h000, 11'h002, 11'h002};

    for (int i = 0; i < 2048; i++) begin
      mem[i]   = 16'h0800;
      mem_w[i] = 16'h0800;
    end
    mem[0] = 16'h1005; mem[1] = 16'h2803; mem[2] = 16'h0000;
    mem_w[11'h7FF] = 16'h0801; mem_w[0] = 16'h1002;

    // Reset values, checked with the clock running.
    reset = 1'b0; en = 1'b0; instr_ready = 1'b0;
    step(); step();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'h000);
    check("rst_pc_wrapdut", 32'(pc_w), 32'h7FF);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_operand", 32'(operand), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", 32'(instr_count), 32'(exp_cnt(0)));

    // Three-word program with HLT, plus the wrap instance in parallel.
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      en = tbl[i].en; instr_ready = tbl[i].rdy;
      step();
      check($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].v));
      check($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
      check($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].h));
      if (tbl[i].v) begin
        check($sformatf("tbl%0d_opcode", i), 32'(opcode), 32'(tbl[i].op));
        check($sformatf("tbl%0d_operand", i), 32'(operand), 32'(tbl[i].opd));
      end
      check($sformatf("tbl%0d_w_valid", i), 32'(instr_valid_w), 32'(tbl[i].wv));
      check($sformatf("tbl%0d_w_pc", i), 32'(pc_w), 32'(tbl[i].wpc));
      check($sformatf("tbl%0d_w_addr", i), 32'(pm_addr_w), 32'(tbl[i].waddr));
      check($sformatf("tbl%0d_w_halted", i), 32'(halted_w), 32'd0);
      if (tbl[i].wv) begin
        check($sformatf("tbl%0d_w_opcode", i), 32'(opcode_w), 32'(tbl[i].wop));
        check($sformatf("tbl%0d_w_operand", i), 32'(operand_w), 32'(tbl[i].wopd));
      end
    end
    check("count_after_prog", 32'(instr_count), 32'(exp_cnt(2)));
    check("count_wrapdut", 32'(instr_count_w), 32'(exp_cnt(3)));

    // Reset while halted clears the flag without a clock edge.
    #2 reset = 1'b0;
    #1;
    check("halt_rst_halted", 32'(halted), 32'd0);
    check("halt_rst_pc", 32'(pc), 32'h000);
    mem[0] = 16'h3844; mem[1] = 16'h1111;
    @(negedge clk);
    reset = 1'b1; en = 1'b1; instr_ready = 1'b0;

    // Stall in VALID for five cycles, then accept.
    step();
    check("stall_fetch_valid", 32'(instr_valid), 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_valid", i), 32'(instr_valid), 32'd1);
      check($sformatf("stall%0d_opcode", i), 32'(opcode), 32'd7);
      check($sformatf("stall%0d_operand", i), 32'(operand), 32'h044);
      check($sformatf("stall%0d_pc", i), 32'(pc), 32'h000);
      check($sformatf("stall%0d_addr", i), 32'(pm_addr), 32'h000);
      step();
    end
    instr_ready = 1'b1;
    #1 check("accept_addr", 32'(pm_addr), 32'h001);
    step();
    check("accept_pc", 32'(pc), 32'h001);
    check("accept_valid", 32'(instr_valid), 32'd0);
    instr_ready = 1'b0;
    step();
    check("second_valid", 32'(instr_valid), 32'd1);
    check("second_opcode", 32'(opcode), 32'd2);

    // Asynchronous reset while VALID.
    #2 reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(instr_valid), 32'd0);
    check("async_rst_pc", 32'(pc), 32'h000);
    check("async_rst_opcode", 32'(opcode), 32'd0);
    @(negedge clk);
    reset = 1'b1; en = 1'b1;
    step();
    check("restart_fetch", 32'(instr_valid), 32'd0);
    step();
    check("restart_valid", 32'(instr_valid), 32'd1);
    check("restart_opcode", 32'(opcode), 32'd7);

    // EN low on the accepting edge parks in IDLE with the PC advanced.
    en = 1'b0; instr_ready = 1'b1;
    step();
    check("idle_valid", 32'(instr_valid), 32'd0);
    check("idle_pc", 32'(pc), 32'h001);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("idle%0d_valid", i), 32'(instr_valid), 32'd0);
      check($sformatf("idle%0d_addr", i), 32'(pm_addr), 32'h001);
    end
    check("idle_count", 32'(instr_count), 32'(exp_cnt(1)));
    en = 1'b1; instr_ready = 1'b0;
    step();
    check("resume_fetch", 32'(instr_valid), 32'd0);
    step();
    check("resume_valid", 32'(instr_valid), 32'd1);
    check("resume_operand", 32'(operand), 32'h111);
    check("resume_pc", 32'(pc), 32'h001);

    // Randomized run against a transaction-level reference.
    reset = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = {5'($urandom_range(1, 31)), 11'($urandom)};
    mem[40] = {5'd0, 11'($urandom)};
    @(negedge clk);
    reset = 1'b1;
    m_pc = 11'h000; m_valid = 1'b0; m_halt = 1'b0; m_pending = 1'b0; acc = 0; done = 1'b0;
    for (int cyc = 0; cyc < 1500 && !done; cyc++) begin
      en = ($urandom_range(0, 3) != 0);
      instr_ready = 1'($urandom_range(0, 1));
      #1 check("rnd_addr", 32'(pm_addr), 32'((m_valid && instr_ready) ? m_pc + 11'd1 : m_pc));
      if (!m_halt) begin
        if (m_valid) begin
          if (instr_ready) begin
            m_pc = m_pc + 11'd1; acc++; m_valid = 1'b0; m_pending = en;
          end
        end else if (m_pending) begin
          m_pending = 1'b0;
          w = mem[m_pc];
          if (w[15:11] == OP_HLT) m_halt = 1'b1; else m_valid = 1'b1;
        end else begin
          m_pending = en;
        end
      end
      step();
      check("rnd_valid", 32'(instr_valid), 32'(m_valid));
      check("rnd_halted", 32'(halted), 32'(m_halt));
      check("rnd_pc", 32'(pc), 32'(m_pc));
      check("rnd_count", 32'(instr_count), 32'(exp_cnt(acc)));
      if (m_valid) begin
        w = mem[m_pc];
        check("rnd_opcode", 32'(opcode), 32'(w[15:11]));
        check("rnd_operand", 32'(operand), 32'(w[10:0]));
      end
      done = m_halt;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL rnd_timeout: got no halt expected halt at pc 0x%0h", m_pc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
